// File: rtl/vgg_pkg.sv
// rtl/vgg_pkg.sv - shared width defaults and FSM state encoding for the conv datapath
package vgg_pkg;

   localparam int SUM_W = 29;
   localparam int ACC_W = 40;
   localparam int CH_W  = 10;
   localparam int OUT_W = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Half-LSB rounding constant for an arithmetic right shift by sh.
   function automatic logic [63:0] round_val(input logic [4:0] sh);
      round_val = (sh == 5'd0) ? 64'd0 : (64'd1 << (sh - 5'd1));
   endfunction

endpackage

// File: rtl/requant.sv
// rtl/requant.sv - round, arithmetic shift and saturate an accumulator to OUT_W (ReLU under PSUM_RELU_EN)
module requant #(
   parameter int ACC_W = vgg_pkg::ACC_W,
   parameter int OUT_W = vgg_pkg::OUT_W
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic [4:0]              shift,
   output logic signed [OUT_W-1:0] data,
   output logic                    sat
);
   import vgg_pkg::*;

   localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shd;

   // One guard bit so adding the round constant can never overflow.
   always_comb begin
      rnd  = (ACC_W+1)'(round_val(shift));
      sum  = (ACC_W+1)'(acc) + rnd;
      shd  = sum >>> shift;
      data = shd[OUT_W-1:0];
      sat  = 1'b0;
`ifdef PSUM_RELU_EN
      if (shd < 0) begin
         data = '0;
      end else if (shd > MAX_V) begin
         data = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end
`else
      if (shd > MAX_V) begin
         data = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (shd < MIN_V) begin
         data = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - per-pixel channel accumulator with bias and requantization (PSUM_RELU_EN selects ReLU)
module psum_accum #(
   parameter int SUM_W = vgg_pkg::SUM_W,
   parameter int ACC_W = vgg_pkg::ACC_W,
   parameter int CH_W  = vgg_pkg::CH_W,
   parameter int OUT_W = vgg_pkg::OUT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CH_W-1:0]         cfg_ch_num,
   input  logic signed [15:0]      cfg_bias,
   input  logic [4:0]              cfg_shift,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [SUM_W-1:0] in_sum,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat
);
   import vgg_pkg::*;

   state_t                  state, state_nxt;
   logic [CH_W-1:0]         cnt;
   logic [CH_W-1:0]         ch_lat;
   logic [CH_W-1:0]         n_eff;
   logic [4:0]              shift_lat;
   logic [4:0]              shift_eff;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;
   logic                    fire;
   logic                    last;
   logic signed [OUT_W-1:0] q_data;
   logic                    q_sat;

   assign fire = in_valid && in_ready;

   // First beat of a pixel uses live config; later beats use the latched copy.
   always_comb begin
      n_eff     = ch_lat;
      shift_eff = shift_lat;
      acc_nxt   = acc + ACC_W'(in_sum);
      if (cnt == '0) begin
         n_eff     = (cfg_ch_num == '0) ? CH_W'(1) : cfg_ch_num;
         shift_eff = cfg_shift;
         acc_nxt   = ACC_W'(cfg_bias) + ACC_W'(in_sum);
      end
      last = (cnt == n_eff - CH_W'(1));
   end

   requant #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_requant (
      .acc   (acc_nxt),
      .shift (shift_eff),
      .data  (q_data),
      .sat   (q_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (fire && last) state_nxt = HOLD;
         HOLD:    if (out_ready)    state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         ch_lat    <= CH_W'(1);
         shift_lat <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (fire) begin
         acc <= acc_nxt;
         if (cnt == '0) begin
            ch_lat    <= n_eff;
            shift_lat <= shift_eff;
         end
         if (last) begin
            cnt      <= '0;
            out_data <= q_data;
            out_sat  <= q_sat;
         end else begin
            cnt <= cnt + CH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_psum_accum.sv
// tb/tb_psum_accum.sv - directed table-driven bench for psum_accum
module tb_psum_accum;

   localparam int SUM_W = 29;
   localparam int CH_W  = 10;
   localparam int OUT_W = 8;
`ifdef PSUM_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic [CH_W-1:0]         cfg_ch_num;
   logic signed [15:0]      cfg_bias;
   logic [4:0]              cfg_shift;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [SUM_W-1:0] in_sum;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;

   int total = 0;
   int bad   = 0;

   psum_accum dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_ch_num (cfg_ch_num),
      .cfg_bias   (cfg_bias),
      .cfg_shift  (cfg_shift),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sat    (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int bias;
      int shift;
      int n;
      int s0, s1, s2, s3;
      int ed;
      int es;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int ch, int bias, int shift, int n,
                               int s0, int s1, int s2, int s3, int ed, int es);
      vec_t v;
      v.ch = ch; v.bias = bias; v.shift = shift; v.n = n;
      v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
      v.ed = ed; v.es = es;
      return v;
   endfunction

   function automatic int pick(vec_t v, int b);
      case (b)
         0:       return v.s0;
         1:       return v.s1;
         2:       return v.s2;
         default: return v.s3;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int ch, input int bias, input int shift, input int s);
      cfg_ch_num = CH_W'(ch);
      cfg_bias   = 16'(bias);
      cfg_shift  = 5'(shift);
      in_sum     = SUM_W'(s);
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      vt[0]  = mk(3, 0,    0,  3, 10, 20, 30, 0, 60, 0);
      vt[1]  = mk(1, 0,    2,  1, 1000, 0, 0, 0, 127, 1);
      vt[2]  = mk(2, 0,    0,  2, -50, -10, 0, 0, RELU ? 0 : -60, 0);
      vt[3]  = mk(1, 0,    1,  1, 3, 0, 0, 0, 2, 0);
      vt[4]  = mk(1, 0,    1,  1, -3, 0, 0, 0, RELU ? 0 : -1, 0);
      vt[5]  = mk(0, 7,    0,  1, 5, 0, 0, 0, 12, 0);
      vt[6]  = mk(2, -100, 0,  2, -100, -100, 0, 0, RELU ? 0 : -128, RELU ? 0 : 1);
      vt[7]  = mk(4, 16,   3,  4, 8, 8, 8, 8, 6, 0);
      vt[8]  = mk(1, 0,    4,  1, 8, 0, 0, 0, 1, 0);
      vt[9]  = mk(1, 0,    4,  1, 7, 0, 0, 0, 0, 0);
      vt[10] = mk(2, 0,    20, 2, 268435455, 268435455, 0, 0, 127, 1);
      vt[11] = mk(1, 0,    0,  1, 127, 0, 0, 0, 127, 0);
      vt[12] = mk(1, 0,    0,  1, 128, 0, 0, 0, 127, 1);
      vt[13] = mk(1, 0,    0,  1, -128, 0, 0, 0, RELU ? 0 : -128, 0);
      vt[14] = mk(1, 0,    0,  1, -129, 0, 0, 0, RELU ? 0 : -128, RELU ? 0 : 1);
      vt[15] = mk(3, -20,  0,  3, 1, 2, 3, 0, RELU ? 0 : -14, 0);

      rst = 1'b1; cfg_ch_num = '0; cfg_bias = '0; cfg_shift = '0;
      in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_in_ready",  int'(in_ready),  1);
      chk("reset_out_data",  int'(out_data),  0);
      chk("reset_out_sat",   int'(out_sat),   0);

      for (int i = 0; i < 16; i++) begin
         for (int b = 0; b < vt[i].n; b++) begin
            chk($sformatf("v%0d_b%0d_in_ready", i, b), int'(in_ready), 1);
            chk($sformatf("v%0d_b%0d_out_valid_low", i, b), int'(out_valid), 0);
            beat(vt[i].ch, vt[i].bias, vt[i].shift, pick(vt[i], b));
         end
         chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
         chk($sformatf("v%0d_in_ready_low", i), int'(in_ready), 0);
         chk($sformatf("v%0d_out_data", i), int'(out_data), vt[i].ed);
         chk($sformatf("v%0d_out_sat", i), int'(out_sat), vt[i].es);
         drain();
         chk($sformatf("v%0d_drained", i), int'(out_valid), 0);
      end

      // Config changed mid-pixel must be ignored: 3 beats, bias 4, shift 1.
      beat(3, 4, 1, 10);
      beat(1, 100, 0, 10);
      chk("midcfg_not_done", int'(out_valid), 0);
      beat(1, 100, 0, 10);
      chk("midcfg_valid", int'(out_valid), 1);
      chk("midcfg_data",  int'(out_data), 17);
      drain();

      // Pending result held against back-pressure while in_valid is asserted.
      beat(1, 0, 0, 42);
      cfg_ch_num = CH_W'(1); in_sum = SUM_W'(99); in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d_valid", k), int'(out_valid), 1);
         chk($sformatf("hold%0d_in_ready", k), int'(in_ready), 0);
         chk($sformatf("hold%0d_data", k), int'(out_data), 42);
         tick();
      end
      in_valid = 1'b0;
      drain();
      chk("hold_released", int'(in_ready), 1);
      beat(2, 0, 0, 5);
      chk("hold_no_beat_consumed", int'(out_valid), 0);
      beat(2, 0, 0, 6);
      chk("hold_next_valid", int'(out_valid), 1);
      chk("hold_next_data", int'(out_data), 11);
      drain();

      // Reset mid-pixel discards the partial sum.
      beat(4, 100, 0, 50);
      beat(4, 100, 0, 50);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_valid", int'(out_valid), 0);
      for (int b = 0; b < 4; b++) beat(4, 5, 0, 1);
      chk("midrst_valid", int'(out_valid), 1);
      chk("midrst_data", int'(out_data), 9);

      // Reset while a result is pending drops it.
      rst = 1'b1; tick(); rst = 1'b0;
      chk("holdrst_out_valid", int'(out_valid), 0);
      chk("holdrst_out_data", int'(out_data), 0);
      chk("holdrst_in_ready", int'(in_ready), 1);
      beat(1, 3, 0, 4);
      chk("holdrst_next_data", int'(out_data), 7);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
